// File: rtl/stream_intf.sv
// Valid/ready stream carrying WIDTH-bit words from a Src to a Snk.
interface StreamIntf #(parameter int WIDTH = 8);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport Src (output valid, data, input ready);
    modport Snk (input valid, data, output ready);
endinterface

// File: rtl/stream_fifo_mem.sv
// Register-array FIFO storage: one synchronous write port, one asynchronous read port.
module stream_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/stream_feeder.sv
// Buffered producer: push handshake in, DEPTH-entry first-word-fall-through FIFO,
// StreamIntf Src out. Outputs derive from registered state only (no empty bypass).
module stream_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_data,
    StreamIntf.Src                   out,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] EMPTY = '0;

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rdata;
    logic             out_valid;
    logic             do_push, do_pop;

    // push_ready ignores out.ready on purpose: no write-through when full.
    assign push_ready = (count != FULL) && !rst;
    assign out_valid  = (count != EMPTY);
    assign do_push    = push_valid && push_ready;
    assign do_pop     = out_valid && out.ready;

    assign out.valid = out_valid;
    // Gate data so never-written entries cannot leak X.
    assign out.data  = out_valid ? rdata : '0;
    assign level     = count;

    stream_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (push_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_feeder.sv
// Self-checking bench for stream_feeder: directed scenarios plus a random run
// compared against a queue-based FIFO model.
module tb_stream_feeder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push_valid = 1'b0;
    logic       push_ready;
    logic [7:0] push_data = '0;
    logic [2:0] level;
    int         n_checks = 0;
    int         n_fail = 0;

    StreamIntf #(.WIDTH(8)) s_if ();

    stream_feeder #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .out        (s_if),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        s_if.ready = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({push_ready, s_if.valid, s_if.data, level} !== {1'b0, 1'b0, 8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: got pr=%b v=%b d=%h lvl=%0d want pr=0 v=0 d=00 lvl=0",
                     push_ready, s_if.valid, s_if.data, level);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({push_ready, s_if.valid, s_if.data, level} !== {1'b1, 1'b0, 8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_idle: got pr=%b v=%b d=%h lvl=%0d want pr=1 v=0 d=00 lvl=0",
                     push_ready, s_if.valid, s_if.data, level);
        end
        @(negedge clk);
    endtask

    task automatic test_single_stall();
        push_valid = 1'b1; push_data = 8'hA5; s_if.ready = 1'b0;
        cycle();
        push_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({s_if.valid, s_if.data, level} !== {1'b1, 8'hA5, 3'd1}) begin
                n_fail++;
                $display("FAIL single_hold[%0d]: got v=%b d=%h lvl=%0d want v=1 d=a5 lvl=1",
                         i, s_if.valid, s_if.data, level);
            end
            cycle();
        end
        s_if.ready = 1'b1;
        cycle();
        s_if.ready = 1'b0;
        n_checks++;
        if ({s_if.valid, s_if.data, level} !== {1'b0, 8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL single_pop: got v=%b d=%h lvl=%0d want v=0 d=00 lvl=0",
                     s_if.valid, s_if.data, level);
        end
    endtask

    task automatic test_fill_backpressure();
        s_if.ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_valid = 1'b1; push_data = 8'(i);
            cycle();
        end
        push_data = 8'h05;
        n_checks++;
        if ({level, push_ready} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_full: got lvl=%0d pr=%b want lvl=4 pr=0", level, push_ready);
        end
        cycle();
        n_checks++;
        if ({level, s_if.data} !== {3'd4, 8'h01}) begin
            n_fail++;
            $display("FAIL fill_no_take: got lvl=%0d d=%h want lvl=4 d=01", level, s_if.data);
        end
        s_if.ready = 1'b1;
        cycle();
        s_if.ready = 1'b0;
        n_checks++;
        if ({level, push_ready, s_if.data} !== {3'd3, 1'b1, 8'h02}) begin
            n_fail++;
            $display("FAIL fill_pop_one: got lvl=%0d pr=%b d=%h want lvl=3 pr=1 d=02",
                     level, push_ready, s_if.data);
        end
        cycle();
        push_valid = 1'b0;
        n_checks++;
        if (level !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_late_take: got lvl=%0d want lvl=4", level);
        end
        s_if.ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            n_checks++;
            if ({s_if.valid, s_if.data} !== {1'b1, 8'(i)}) begin
                n_fail++;
                $display("FAIL fill_drain[%0d]: got v=%b d=%h want v=1 d=%h",
                         i, s_if.valid, s_if.data, 8'(i));
            end
            cycle();
        end
        s_if.ready = 1'b0;
        n_checks++;
        if ({s_if.valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL fill_empty: got v=%b lvl=%0d want v=0 lvl=0", s_if.valid, level);
        end
    endtask

    task automatic test_streaming_wrap();
        push_valid = 1'b1; s_if.ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_data = 8'(i);
            cycle();
            n_checks++;
            if ({s_if.valid, s_if.data, level} !== {1'b1, 8'(i), 3'd1}) begin
                n_fail++;
                $display("FAIL stream[%0d]: got v=%b d=%h lvl=%0d want v=1 d=%h lvl=1",
                         i, s_if.valid, s_if.data, level, 8'(i));
            end
        end
        push_valid = 1'b0;
        cycle();
        s_if.ready = 1'b0;
        n_checks++;
        if ({s_if.valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL stream_end: got v=%b lvl=%0d want v=0 lvl=0", s_if.valid, level);
        end
    endtask

    task automatic test_full_simul_pop();
        logic [7:0] q[$];
        logic [7:0] w;
        s_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom);
            push_valid = 1'b1; push_data = w; q.push_back(w);
            cycle();
        end
        w = 8'($urandom);
        push_data = w; s_if.ready = 1'b1;
        cycle();
        void'(q.pop_front());
        n_checks++;
        if ({level, s_if.data} !== {3'd3, q[0]}) begin
            n_fail++;
            $display("FAIL full_pop_only: got lvl=%0d d=%h want lvl=3 d=%h", level, s_if.data, q[0]);
        end
        cycle();
        void'(q.pop_front());
        q.push_back(w);
        push_valid = 1'b0;
        n_checks++;
        if ({level, s_if.data} !== {3'd3, q[0]}) begin
            n_fail++;
            $display("FAIL full_push_lands: got lvl=%0d d=%h want lvl=3 d=%h", level, s_if.data, q[0]);
        end
        while (q.size() != 0) begin
            n_checks++;
            if ({s_if.valid, s_if.data} !== {1'b1, q[0]}) begin
                n_fail++;
                $display("FAIL full_drain: got v=%b d=%h want v=1 d=%h", s_if.valid, s_if.data, q[0]);
            end
            cycle();
            void'(q.pop_front());
        end
        s_if.ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        s_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1; push_data = 8'h70 + 8'(i);
            cycle();
        end
        push_valid = 1'b0;
        n_checks++;
        if (level !== 3'd3) begin
            n_fail++;
            $display("FAIL rstmid_pre: got lvl=%0d want lvl=3", level);
        end
        s_if.ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({s_if.valid, s_if.data, level, push_ready} !== {1'b0, 8'h00, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got v=%b d=%h lvl=%0d pr=%b want v=0 d=00 lvl=0 pr=0",
                     s_if.valid, s_if.data, level, push_ready);
        end
        @(negedge clk);
        rst = 1'b0; s_if.ready = 1'b0;
        push_valid = 1'b1; push_data = 8'h3C;
        cycle();
        push_valid = 1'b0;
        n_checks++;
        if ({s_if.valid, s_if.data, level} !== {1'b1, 8'h3C, 3'd1}) begin
            n_fail++;
            $display("FAIL rstmid_after: got v=%b d=%h lvl=%0d want v=1 d=3c lvl=1",
                     s_if.valid, s_if.data, level);
        end
        s_if.ready = 1'b1;
        cycle();
        s_if.ready = 1'b0;
        n_checks++;
        if ({s_if.valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL rstmid_stale: got v=%b lvl=%0d want v=0 lvl=0", s_if.valid, level);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic       exp_pr, exp_v, take, pop;
        logic [7:0] exp_d;
        for (int n = 0; n < 400; n++) begin
            push_valid = 1'($urandom_range(0, 1));
            s_if.ready = ($urandom_range(0, 3) != 0) ? ((n / 50) % 2 == 0) : 1'($urandom_range(0, 1));
            push_data  = 8'($urandom);
            exp_pr = (q.size() != 4);
            exp_v  = (q.size() != 0);
            exp_d  = exp_v ? q[0] : 8'h00;
            n_checks++;
            if ({push_ready, s_if.valid, s_if.data, level} !== {exp_pr, exp_v, exp_d, 3'(q.size())}) begin
                n_fail++;
                $display("FAIL random[%0d]: got pr=%b v=%b d=%h lvl=%0d want pr=%b v=%b d=%h lvl=%0d",
                         n, push_ready, s_if.valid, s_if.data, level, exp_pr, exp_v, exp_d, q.size());
            end
            take = push_valid && exp_pr;
            pop  = s_if.ready && exp_v;
            cycle();
            if (pop)  void'(q.pop_front());
            if (take) q.push_back(push_data);
        end
        push_valid = 1'b0; s_if.ready = 1'b1;
        for (int n = 0; n < 8 && q.size() != 0; n++) begin
            cycle();
            void'(q.pop_front());
        end
        s_if.ready = 1'b0;
        n_checks++;
        if ({s_if.valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL random_drain: got v=%b lvl=%0d want v=0 lvl=0", s_if.valid, level);
        end
    endtask

    initial begin
        s_if.ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_stall();
        test_fill_backpressure();
        test_streaming_wrap();
        test_full_simul_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
